// File: rtl/inert_multi_intf.sv
// -----------------------------------------------------------------------------
// inert_multi_intf
//
// Front end for an inertial sensor behind an external SPI master. After
// power-up it waits 2^INIT_W-1 cycles, issues four configuration writes, then
// idles in WAIT. Each data-ready (INT) triggers 2*N_CH single-byte register
// reads (low byte then high byte of every channel), spaced 2^STEP_W cycles
// apart. When the last read completes, all channels update together and vld
// pulses for one cycle. A watchdog flags a sensor that stops raising INT.
//
// Optional feature: define INERT_SPIKE_FILT_EN to replace any channel whose
// signed magnitude exceeds SPIKE_LIM with zero at update time.
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   INT          in   sensor data-ready, asynchronous level
//   spi_done     in   one-cycle pulse, SPI transaction complete
//   spi_rd_data  in   SPI read data, byte in [7:0]
//   spi_wrt      out  one-cycle transaction start strobe
//   spi_cmd      out  command word, zero whenever spi_wrt is low
//   data         out  channel i in [16i+15:16i], signed, held between updates
//   vld          out  one-cycle pulse coincident with new data
//   timeout      out  sticky: no INT for 2^TMO_W-1 cycles in WAIT
// -----------------------------------------------------------------------------
module inert_multi_intf #(
    parameter int unsigned       N_CH      = 2,
    parameter logic [8*N_CH-1:0] CH_ADDR   = {8'h2C, 8'h22},
    parameter int unsigned       INIT_W    = 16,
    parameter int unsigned       STEP_W    = 10,
    parameter int unsigned       TMO_W     = 20,
    parameter logic [15:0]       SPIKE_LIM = 16'h1F00
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 INT,
    input  logic                 spi_done,
    input  logic [15:0]          spi_rd_data,
    output logic                 spi_wrt,
    output logic [15:0]          spi_cmd,
    output logic [16*N_CH-1:0]   data,
    output logic                 vld,
    output logic                 timeout
);

    localparam int unsigned N_TXN  = 2 * N_CH;
    localparam logic [2:0]  K_LAST = 3'(N_TXN - 1);

    typedef enum logic [2:0] {
        ST_INIT1, ST_INIT2, ST_INIT3, ST_INIT4, ST_WAIT, ST_READ
    } state_t;

    state_t               state_q, state_d;
    logic [INIT_W-1:0]    timer_q, timer_d;
    logic [2:0]           k_q, k_d;
    logic                 int_ff1_q, int_ff1_d;
    logic                 int_ff2_q, int_ff2_d;
    logic [7:0]           shadow_q [N_TXN];
    logic [7:0]           shadow_d [N_TXN];
    logic [16*N_CH-1:0]   data_q, data_d;
    logic                 vld_q, vld_d;
    logic                 wrt_q, wrt_d;
    logic [15:0]          cmd_q, cmd_d;
    logic [TMO_W-1:0]     wdog_q, wdog_d;
    logic                 timeout_q, timeout_d;
    logic                 step_due;

    // Only the byte lane carries data; the upper lane is don't-care.
    logic unused_rd_hi;
    assign unused_rd_hi = ^spi_rd_data[15:8];

    // Read command for transaction k: even k is a channel's low byte at its
    // base address, odd k the high byte at base+1. Bit 15 is the read flag.
    function automatic logic [15:0] read_cmd(input logic [2:0] k);
        logic [7:0] addr;
        addr = 8'h00;
        for (int i = 0; i < N_CH; i++) begin
            if (k[2:1] == 2'(i)) addr = CH_ADDR[8*i +: 8] + {7'd0, k[0]};
        end
        return {1'b1, addr[6:0], 8'h00};
    endfunction

    function automatic logic [15:0] spike_filt(input logic [15:0] raw);
`ifdef INERT_SPIKE_FILT_EN
        if (($signed(raw) > $signed(SPIKE_LIM)) || ($signed(raw) < -$signed(SPIKE_LIM)))
            return 16'h0000;
        else
            return raw;
`else
        return raw;
`endif
    endfunction

    assign step_due = &timer_q[STEP_W-1:0];

    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        timer_d   = timer_q + 1'b1;
        k_d       = k_q;
        int_ff1_d = INT;
        int_ff2_d = int_ff1_q;
        shadow_d  = shadow_q;
        data_d    = data_q;
        vld_d     = 1'b0;
        wrt_d     = 1'b0;
        cmd_d     = 16'h0000;
        wdog_d    = '0;
        timeout_d = timeout_q;

        case (state_q)
            ST_INIT1: if (&timer_q) begin
                wrt_d = 1'b1; cmd_d = 16'h0D02; state_d = ST_INIT2;
            end
            ST_INIT2: if (step_due) begin
                wrt_d = 1'b1; cmd_d = 16'h1053; state_d = ST_INIT3;
            end
            ST_INIT3: if (step_due) begin
                wrt_d = 1'b1; cmd_d = 16'h1150; state_d = ST_INIT4;
            end
            ST_INIT4: if (step_due) begin
                wrt_d = 1'b1; cmd_d = 16'h1460; state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Saturating watchdog; the flag stays set until a read starts.
                wdog_d = (&wdog_q) ? wdog_q : wdog_q + 1'b1;
                if (&wdog_q) timeout_d = 1'b1;
                if (int_ff2_q) begin
                    wrt_d     = 1'b1;
                    cmd_d     = read_cmd(3'd0);
                    k_d       = 3'd0;
                    timer_d   = '0;
                    timeout_d = 1'b0;
                    state_d   = ST_READ;
                end
            end
            ST_READ: begin
                if (spi_done) begin
                    for (int i = 0; i < N_TXN; i++) begin
                        if (k_q == 3'(i)) shadow_d[i] = spi_rd_data[7:0];
                    end
                end
                if (step_due) begin
                    if (k_q != K_LAST) begin
                        wrt_d   = 1'b1;
                        cmd_d   = read_cmd(k_q + 3'd1);
                        k_d     = k_q + 3'd1;
                        timer_d = '0;
                    end else begin
                        // Uses shadow_d so a byte landing on this very cycle
                        // is not lost.
                        for (int i = 0; i < N_CH; i++) begin
                            data_d[16*i +: 16] = spike_filt({shadow_d[2*i+1], shadow_d[2*i]});
                        end
                        vld_d   = 1'b1;
                        state_d = ST_WAIT;
                    end
                end
            end
            default: state_d = ST_INIT1;
        endcase
    end

    // NOTE: state updates use non-blocking assignments so every flop samples
    // the pre-edge value of its source regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_INIT1;
            timer_q   <= '0;
            k_q       <= 3'd0;
            int_ff1_q <= 1'b0;
            int_ff2_q <= 1'b0;
            // NOTE: the shadow bytes are a small register file, reset
            // explicitly because a sequence with a missing response must read
            // back a defined value rather than power-up garbage.
            for (int i = 0; i < N_TXN; i++) shadow_q[i] <= 8'h00;
            data_q    <= '0;
            vld_q     <= 1'b0;
            wrt_q     <= 1'b0;
            cmd_q     <= 16'h0000;
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            k_q       <= k_d;
            int_ff1_q <= int_ff1_d;
            int_ff2_q <= int_ff2_d;
            for (int i = 0; i < N_TXN; i++) shadow_q[i] <= shadow_d[i];
            data_q    <= data_d;
            vld_q     <= vld_d;
            wrt_q     <= wrt_d;
            cmd_q     <= cmd_d;
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
        end
    end

    assign spi_wrt = wrt_q;
    assign spi_cmd = cmd_q;
    assign data    = data_q;
    assign vld     = vld_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_inert_multi_intf.sv
// -----------------------------------------------------------------------------
// tb_inert_multi_intf
//
// Self-checking bench for inert_multi_intf with three channels and shortened
// counters. A responder process plays the SPI master and sensor register map
// (a byte array); the expected channel values come from that register map and
// the list of channel base addresses, independent of the design's internals.
// -----------------------------------------------------------------------------
module tb_inert_multi_intf;

    localparam int N_CH   = 3;
    localparam int N_TXN  = 2 * N_CH;
    localparam int INIT_W = 10;
    localparam int STEP_W = 4;
    localparam int TMO_W  = 8;
    localparam int STEP   = 1 << STEP_W;
    localparam int INIT_T = 1 << INIT_W;
    localparam int LIM    = 'h1F00;
    localparam logic [8*N_CH-1:0] CH_ADDR = {8'h28, 8'h2C, 8'h22};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        int_in;
    logic        spi_done;
    logic [15:0] spi_rd_data;
    logic        spi_wrt;
    logic [15:0] spi_cmd;
    logic [16*N_CH-1:0] data;
    logic        vld;
    logic        timeout;

    always #5 clk = ~clk;

    inert_multi_intf #(
        .N_CH(N_CH), .CH_ADDR(CH_ADDR), .INIT_W(INIT_W),
        .STEP_W(STEP_W), .TMO_W(TMO_W), .SPIKE_LIM(16'h1F00)
    ) dut (
        .clk(clk), .rst_n(rst_n), .INT(int_in), .spi_done(spi_done),
        .spi_rd_data(spi_rd_data), .spi_wrt(spi_wrt), .spi_cmd(spi_cmd),
        .data(data), .vld(vld), .timeout(timeout)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Written by the responder/monitor only.
    int          cyc = 0;
    int          wrt_cyc[$];
    logic [15:0] wrt_cmd[$];
    int          vld_cyc[$];
    logic [47:0] vld_data[$];
    int          cmd_bad = 0;
    int          wrt_dbl = 0;
    int          resp_cnt = 0;
    int          stray_done = 0;
    logic [7:0]  pend = 8'h00;
    bit          prev_wrt = 1'b0;

    // Written by the main sequence only.
    logic [7:0]  mem [128];
    logic [15:0] skip_cmd = 16'hFFFF;
    int          stray_req = 0;
    logic [7:0]  sh_m [N_TXN];
    int          ch_base [N_CH] = '{'h22, 'h2C, 'h28};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    function automatic int txn_addr(input int k);
        return ch_base[k / 2] + (k % 2);
    endfunction

    function automatic logic [15:0] exp_cmd(input int k);
        return 16'h8000 | 16'((txn_addr(k) & 'h7F) << 8);
    endfunction

    function automatic logic [15:0] model_filt(input logic [15:0] raw);
        int v;
        v = int'($signed(raw));
`ifdef INERT_SPIKE_FILT_EN
        if (v > LIM || v < -LIM) return 16'h0000;
`endif
        return raw;
    endfunction

    function automatic logic [47:0] exp_data();
        logic [47:0] r;
        r = '0;
        for (int i = 0; i < N_CH; i++) r[16*i +: 16] = model_filt({sh_m[2*i+1], sh_m[2*i]});
        return r;
    endfunction

    task automatic randomize_mem();
        for (int a = 0; a < 128; a++) mem[a] = 8'($urandom);
    endtask

    // SPI master + sensor model, and output monitor. Acts on falling edges.
    initial begin
        spi_done    = 1'b0;
        spi_rd_data = 16'h0000;
        forever begin
            @(negedge clk);
            cyc++;
            spi_done    = 1'b0;
            spi_rd_data = 16'h0000;
            if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) begin
                    spi_done    = 1'b1;
                    spi_rd_data = {8'h00, pend};
                end
            end else if (stray_req != stray_done) begin
                stray_done  = stray_req;
                spi_done    = 1'b1;
                spi_rd_data = 16'h00EE;
            end
            if (spi_wrt) begin
                wrt_cyc.push_back(cyc);
                wrt_cmd.push_back(spi_cmd);
                if (spi_cmd[15] && spi_cmd != skip_cmd) begin
                    pend     = mem[spi_cmd[14:8]];
                    resp_cnt = $urandom_range(1, 12);
                end
            end
            if (!spi_wrt && spi_cmd !== 16'h0000) cmd_bad++;
            if (spi_wrt && prev_wrt) wrt_dbl++;
            prev_wrt = spi_wrt;
            if (vld) begin
                vld_cyc.push_back(cyc);
                vld_data.push_back(data);
            end
        end
    end

    // Checks the four configuration writes following a reset release at rel.
    task automatic check_init(input int rel);
        int wb, g;
        logic [15:0] cfg [4];
        cfg = '{16'h0D02, 16'h1053, 16'h1150, 16'h1460};
        wb = wrt_cyc.size();
        g  = 0;
        while (wrt_cyc.size() < wb + 4 && g < INIT_T + 200) begin step(1); g++; end
        chk("init_n_wrt", wrt_cyc.size() - wb, 4);
        if (wrt_cyc.size() >= wb + 4) begin
            for (int j = 0; j < 4; j++) begin
                chk($sformatf("init_cmd%0d", j), wrt_cmd[wb+j], cfg[j]);
                chk($sformatf("init_cyc%0d", j), wrt_cyc[wb+j] - rel, INIT_T + STEP * j);
            end
        end
        step(40);
        chk("init_hold_wait", wrt_cyc.size() - wb, 4);
    endtask

    // One INT-triggered read sequence; INT is driven right after a falling edge.
    task automatic run_seq(input bit hold, input bit chk_tmo, input logic [15:0] skip);
        int wb, vb, c, g;
        skip_cmd = skip;
        for (int k = 0; k < N_TXN; k++)
            if (exp_cmd(k) != skip) sh_m[k] = mem[txn_addr(k)];
        wb = wrt_cyc.size();
        vb = vld_cyc.size();
        c  = cyc;
        int_in = 1'b1;
        step(2);
        if (chk_tmo) chk("tmo_before_read", timeout, 1'b1);
        step(1);
        chk("first_wrt", spi_wrt, 1'b1);
        if (chk_tmo) chk("tmo_cleared", timeout, 1'b0);
        if (!hold) int_in = 1'b0;
        g = 0;
        while (vld_cyc.size() <= vb && g < N_TXN * STEP + 40) begin step(1); g++; end
        chk("vld_seen", vld_cyc.size() - vb, 1);
        chk("n_wrt", wrt_cyc.size() - wb, N_TXN);
        if (wrt_cyc.size() >= wb + N_TXN && vld_cyc.size() > vb) begin
            for (int j = 0; j < N_TXN; j++) begin
                chk($sformatf("rd_cmd%0d", j), wrt_cmd[wb+j], exp_cmd(j));
                chk($sformatf("rd_cyc%0d", j), wrt_cyc[wb+j] - c, 3 + STEP * j);
            end
            // INT_ff2 rises two edges after INT is driven.
            chk("vld_latency", vld_cyc[vb] - (c + 2), 2 * N_CH * STEP + 1);
            chk("vld_data", vld_data[vb], exp_data());
        end
        if (hold) begin
            step(1);
            chk("relaunch_wrt", spi_wrt, 1'b1);
            chk("relaunch_cmd", spi_cmd, exp_cmd(0));
            int_in = 1'b0;
            g = 0;
            while (vld_cyc.size() <= vb + 1 && g < N_TXN * STEP + 40) begin step(1); g++; end
            chk("relaunch_vld", vld_cyc.size() - vb, 2);
            chk("relaunch_data", data, exp_data());
        end
        step(5);
        chk("vld_single", vld_cyc.size() - vb, hold ? 2 : 1);
        chk("data_held", data, exp_data());
        skip_cmd = 16'hFFFF;
    endtask

    initial begin
        int rel, c, vb;
        rst_n  = 1'b0;
        int_in = 1'b0;
        for (int k = 0; k < N_TXN; k++) sh_m[k] = 8'h00;
        randomize_mem();
        step(3);
        chk("rst_wrt", spi_wrt, 1'b0);
        chk("rst_cmd", spi_cmd, 16'h0000);
        chk("rst_data", data, 48'h0);
        chk("rst_vld", vld, 1'b0);
        chk("rst_tmo", timeout, 1'b0);

        rst_n = 1'b1;
        rel   = cyc;
        check_init(rel);

        // Directed register contents: ch0 = 1234, ch1 = 5678.
        mem['h22] = 8'h34; mem['h23] = 8'h12;
        mem['h2C] = 8'h78; mem['h2D] = 8'h56;
        run_seq(1'b0, 1'b0, 16'hFFFF);
        chk("data_dir_ch01", data[31:0], 32'h5678_1234);

        for (int r = 0; r < 3; r++) begin
            randomize_mem();
            run_seq(1'b0, 1'b0, 16'hFFFF);
        end

        // Spike boundary values on ch0/ch1.
        mem['h22] = 8'h00; mem['h23] = 8'h20;
        mem['h2C] = 8'h00; mem['h2D] = 8'hE0;
        run_seq(1'b0, 1'b0, 16'hFFFF);
`ifdef INERT_SPIKE_FILT_EN
        chk("spike_ch01", data[31:0], 32'h0000_0000);
`else
        chk("spike_ch01", data[31:0], 32'hE000_2000);
`endif

        // INT held high across the return to WAIT restarts immediately.
        randomize_mem();
        run_seq(1'b1, 1'b0, 16'hFFFF);

        // A done pulse in WAIT must be ignored; the last read gets no reply so
        // its shadow byte keeps the previous sequence's value.
        randomize_mem();
        stray_req++;
        step(3);
        run_seq(1'b0, 1'b0, 16'hA900);

        // Watchdog: around 2^TMO_W cycles idle in WAIT.
        step(245);
        chk("tmo_low_early", timeout, 1'b0);
        step(10);
        chk("tmo_set", timeout, 1'b1);
        randomize_mem();
        run_seq(1'b0, 1'b1, 16'hFFFF);
        chk("tmo_after_read", timeout, 1'b0);

        // Reset in the middle of the third read transaction.
        randomize_mem();
        vb = vld_cyc.size();
        c  = cyc;
        int_in = 1'b1;
        step(3);
        int_in = 1'b0;
        step(2 * STEP + 5);
        rst_n = 1'b0;
        step(1);
        chk("midrst_data", data, 48'h0);
        chk("midrst_wrt", spi_wrt, 1'b0);
        step(2);
        rst_n = 1'b1;
        rel   = cyc;
        for (int k = 0; k < N_TXN; k++) sh_m[k] = 8'h00;
        check_init(rel);
        chk("midrst_no_vld", vld_cyc.size() - vb, 0);
        chk("midrst_data_zero", data, 48'h0);
        chk("midrst_c_used", cyc > c, 1'b1);

        chk("cmd_zero_idle", cmd_bad, 0);
        chk("wrt_one_cycle", wrt_dbl, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got stuck, want finish");
        $fatal(1, "simulation time limit");
    end

endmodule

// File: doc/inert_multi_intf.md
INERT_MULTI_INTF -- requirements
Module: inert_multi_intf

Interface
REQ-001 SHALL have parameter N_CH, default 2: number of 16-bit sensor channels read per INT, legal 1..4.
REQ-002 SHALL have parameter CH_ADDR [8*N_CH-1:0], default {8'h2C,8'h22}: low-byte register address of channel i in bits [8i+7:8i]; the high byte is at address+1.
REQ-003 SHALL have parameter INIT_W, default 16: width of the power-up wait count.
REQ-004 SHALL have parameter STEP_W, default 10: width of the per-transaction spacing count.
REQ-005 SHALL have parameter TMO_W, default 20: width of the INT-absence watchdog.
REQ-006 SHALL have parameter SPIKE_LIM, default 16'h1F00: spike-filter magnitude limit.
REQ-007 clk  input  1  clock, rising edge.
REQ-008 rst_n  input  1  reset, asynchronous, active-low.
REQ-009 INT  input  1  sensor data-ready, asynchronous level.
REQ-010 spi_done  input  1  one-cycle pulse from the external SPI master when a transaction completes.
REQ-011 spi_rd_data  input  16  read data from the SPI master; the byte is in [7:0].
REQ-012 spi_wrt  output  1  one-cycle transaction start strobe.
REQ-013 spi_cmd  output  16  command word, sampled by the SPI master when spi_wrt is high.
REQ-014 data  output  16*N_CH  channel i is in [16i+15:16i], signed, held between updates.
REQ-015 vld  output  1  one-cycle pulse when data updates.
REQ-016 timeout  output  1  sticky flag: no INT seen within 2^TMO_W-1 cycles.

Function
REQ-017 The block SHALL double-flop INT before any use; only INT_ff2 affects behaviour.
REQ-018 The state machine SHALL have states INIT1, INIT2, INIT3, INIT4, WAIT and READ.
REQ-019 A free-running timer of width INIT_W SHALL be cleared on entry to READ and on every spi_wrt issued in READ.
REQ-020 INIT1 SHALL wait until all INIT_W timer bits are 1, then pulse spi_wrt with cmd 16'h0D02 and go to INIT2.
REQ-021 INIT2, INIT3 and INIT4 SHALL each wait until timer[STEP_W-1:0] is all 1s, then pulse spi_wrt.
  - Commands: INIT2 16'h1053, INIT3 16'h1150, INIT4 16'h1460.
  - Next state in order; INIT4 goes to WAIT.
REQ-022 In WAIT with INT_ff2=1, the block SHALL pulse spi_wrt with the read command for transaction index k=0, set k=0, clear the timer and go to READ.
REQ-023 The read command for index k SHALL be {1'b1, addr[6:0], 8'h00}.
  - addr = CH_ADDR byte (k>>1) + (k&1).
  - Even k reads the low byte; odd k reads the high byte.
REQ-024 In READ, spi_done SHALL capture spi_rd_data[7:0] into shadow byte k; spi_done in any other state SHALL be ignored.
REQ-025 In READ, when timer[STEP_W-1:0] is all 1s:
  - if k<2*N_CH-1: pulse spi_wrt with the command for k+1 and increment k;
  - else: return to WAIT, load every data channel from its shadow bytes, and assert vld for exactly the following cycle, coincident with the new data.
REQ-026 spi_cmd SHALL be 16'h0000 whenever spi_wrt is low.
REQ-027 INT is level-sensitive: INT_ff2 still high on return to WAIT SHALL start a new sequence immediately; INT during INIT or READ SHALL be ignored.
REQ-028 A watchdog counter of width TMO_W SHALL count in WAIT, clear outside WAIT, and saturate.
  - At all 1s it SHALL set timeout.
  - timeout SHALL clear on the next WAIT-to-READ transition.
REQ-029 Total latency from INT_ff2 high in WAIT to vld SHALL be 2*N_CH*(2^STEP_W)+1 cycles.

Reset
REQ-030 rst_n low SHALL immediately force: state INIT1, timer 0, k 0, INT flops 0, shadow bytes 0, data 0, vld 0, timeout 0, spi_wrt 0, spi_cmd 0.
REQ-031 Reset asserted mid-READ SHALL abandon the sequence with no vld; the full INIT sequence SHALL re-run after release.

Configuration
REQ-032 With macro INERT_SPIKE_FILT_EN defined, a channel value greater than SPIKE_LIM or less than -SPIKE_LIM (signed compare) SHALL load as 16'h0000 at data update.
REQ-033 Without INERT_SPIKE_FILT_EN, data SHALL load the raw shadow value.

Verification
REQ-034 Reset release, defaults, no INT: spi_cmd 0D02 at cycle 65535, then 1053, 1150, 1460, each spaced 1024 cycles; state then holds in WAIT.
REQ-035 INT high in WAIT, SPI model returns 8'h34, 8'h12, 8'h78, 8'h56: spi_cmd sequence A200, A300, AC00, AD00; data = 32'h5678_1234; single vld pulse 4097 cycles after INT_ff2.
REQ-036 N_CH=3 with CH_ADDR byte 2 = 8'h28: 6 transactions, the last two being A800 and A900; vld only after the sixth step.
REQ-037 INT held low for 2^20 cycles: timeout rises; on a later INT it clears when the read starts.
REQ-038 Channel 0 reads 16'h2000 and channel 1 reads 16'hE000: result is 0/0 with INERT_SPIKE_FILT_EN defined, 2000/E000 without it.
REQ-039 rst_n pulsed low during the third transaction: no vld, data stays 0, and the INIT1 wait restarts.
